// File: rtl/rv32i_types.sv
// Shared RV32I backend types: physical register indices, CDB broadcast and
// the dispatch packet handed to the load/store queues, plus store-queue
// FSM states and store funct3 encodings.
package rv32i_types;

  localparam int PHYS_REG_IDX = 5;
  localparam int ROB_IDX_BITS = 5;

  typedef struct packed {
    logic                  valid;
    logic [PHYS_REG_IDX:0] pd;
    logic [31:0]           value;
  } cdb_entry_t;

  typedef struct packed {
    logic                    valid;
    logic [PHYS_REG_IDX:0]   ps1;
    logic                    ps1_valid;
    logic [PHYS_REG_IDX:0]   ps2;
    logic                    ps2_valid;
    logic [31:0]             imm;
    logic [2:0]              funct3;
    logic [ROB_IDX_BITS-1:0] rob_idx;
  } dispatch_to_lsq_t;

  typedef enum logic {
    IDLE,
    WAIT_RESP
  } sq_state_t;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

endpackage

// File: rtl/store_queue_lane_align.sv
// Store lane alignment: turns funct3, byte offset and raw store data into
// the byte write mask and lane-replicated write data for data memory.
module store_lane_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [3:0]  wmask,
  output logic [31:0] wdata
);

  // Pick mask and replicated data by access size; misalignment is not checked.
  always_comb begin
    wmask = 4'b0000;
    wdata = 32'h0;
    case (funct3)
      SB: begin
        wmask = 4'b0001 << offset;
        wdata = {4{data[7:0]}};
      end
      SH: begin
        wmask = 4'b0011 << offset;
        wdata = {2{data[15:0]}};
      end
      SW: begin
        wmask = 4'b1111;
        wdata = data;
      end
      default: begin
        wmask = 4'b0000;
        wdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/store_queue.sv
// In-order circular store queue. Entries collect their base and data
// operands from the regfile or the CDBs, fold the base into imm to form the
// effective address, and the head store is sent to memory only once it is
// also the ROB head. The entry array and head pointer are exported so the
// load reservation station can build its store masks.
module store_queue
  import rv32i_types::*;
#(
  parameter int SQ_LENGTH = 4,
  parameter int NUM_CDB   = 2,
  parameter int ROB_IDX_W = ROB_IDX_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  cdb_entry_t                  cdb,
  input  cdb_entry_t                  cdb2,
  input  dispatch_to_lsq_t            dispatch_to_lsq,
  input  logic                        dispatch_is_store,
  input  logic                        dispatch_stall,
  output logic                        is_sq_full,
  output logic [PHYS_REG_IDX:0]       ps1_s,
  input  logic [31:0]                 ps1_value,
  output logic [PHYS_REG_IDX:0]       ps2_s,
  input  logic [31:0]                 ps2_value,
  input  logic [ROB_IDX_W-1:0]        rob_head_idx,
  output dispatch_to_lsq_t            squeue [SQ_LENGTH],
  output logic [$clog2(SQ_LENGTH)-1:0] sq_head,
  output logic                        sq_dequeued,
  output logic                        dmem_req,
  output logic [31:0]                 dmem_addr,
  output logic [3:0]                  dmem_wmask,
  output logic [31:0]                 dmem_wdata,
  input  logic                        dmem_resp,
  output logic                        store_done_valid,
  output logic [ROB_IDX_W-1:0]        store_done_rob_idx
);

  localparam int PTR_W = $clog2(SQ_LENGTH);
  localparam int CNT_W = PTR_W + 1;

  dispatch_to_lsq_t entries_q [SQ_LENGTH];
  dispatch_to_lsq_t entries_d [SQ_LENGTH];
  logic [31:0]      data_q    [SQ_LENGTH];
  logic [31:0]      data_d    [SQ_LENGTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  sq_state_t        state_q;
  sq_state_t        state_d;

  cdb_entry_t       cdb_bus [NUM_CDB];
  dispatch_to_lsq_t enq_entry;
  logic [31:0]      enq_data;
  logic             enq;
  logic             head_ready;

  assign cdb_bus[0] = cdb;
  assign cdb_bus[1] = cdb2;

  assign ps1_s      = dispatch_to_lsq.ps1;
  assign ps2_s      = dispatch_to_lsq.ps2;
  assign is_sq_full = (count_q == CNT_W'(SQ_LENGTH));
  assign sq_head    = head_q;
  assign squeue     = entries_q;

  assign enq = dispatch_to_lsq.valid && dispatch_is_store && !dispatch_stall && !is_sq_full;

  assign head_ready = entries_q[head_q].valid && entries_q[head_q].ps1_valid &&
                      entries_q[head_q].ps2_valid &&
                      (entries_q[head_q].rob_idx == rob_head_idx);

  assign dmem_addr          = {entries_q[head_q].imm[31:2], 2'b00};
  assign store_done_rob_idx = entries_q[head_q].rob_idx;

  store_lane_align u_lane_align (
    .funct3 (entries_q[head_q].funct3),
    .offset (entries_q[head_q].imm[1:0]),
    .data   (data_q[head_q]),
    .wmask  (dmem_wmask),
    .wdata  (dmem_wdata)
  );

  // Build the incoming entry, letting a same-cycle CDB hit override the regfile.
  always_comb begin
    logic [31:0] base;
    logic        base_ok;
    logic [31:0] src;
    logic        src_ok;
    base    = ps1_value;
    base_ok = dispatch_to_lsq.ps1_valid;
    src     = ps2_value;
    src_ok  = dispatch_to_lsq.ps2_valid;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (cdb_bus[c].valid && (cdb_bus[c].pd == dispatch_to_lsq.ps1)) begin
        base    = cdb_bus[c].value;
        base_ok = 1'b1;
      end
      if (cdb_bus[c].valid && (cdb_bus[c].pd == dispatch_to_lsq.ps2)) begin
        src    = cdb_bus[c].value;
        src_ok = 1'b1;
      end
    end
    enq_entry           = dispatch_to_lsq;
    enq_entry.valid     = 1'b1;
    enq_entry.ps1_valid = base_ok;
    enq_entry.ps2_valid = src_ok;
    enq_entry.imm       = base_ok ? (dispatch_to_lsq.imm + base) : dispatch_to_lsq.imm;
    enq_data            = src_ok ? src : 32'h0;
  end

  // Next entry state: CDB wakeup, then head retirement, then tail enqueue.
  always_comb begin
    entries_d = entries_q;
    data_d    = data_q;
    for (int i = 0; i < SQ_LENGTH; i++) begin
      if (entries_q[i].valid) begin
        for (int c = 0; c < NUM_CDB; c++) begin
          if (cdb_bus[c].valid && !entries_d[i].ps1_valid &&
              (cdb_bus[c].pd == entries_d[i].ps1)) begin
            entries_d[i].ps1_valid = 1'b1;
            entries_d[i].imm       = entries_d[i].imm + cdb_bus[c].value;
          end
          if (cdb_bus[c].valid && !entries_d[i].ps2_valid &&
              (cdb_bus[c].pd == entries_d[i].ps2)) begin
            entries_d[i].ps2_valid = 1'b1;
            data_d[i]              = cdb_bus[c].value;
          end
        end
      end
    end
    if (sq_dequeued) begin
      entries_d[head_q].valid = 1'b0;
    end
    if (enq) begin
      entries_d[tail_q] = enq_entry;
      data_d[tail_q]    = enq_data;
    end
  end

  // Issue FSM: wait for a ready ROB-head store, then hold the request until accepted.
  always_comb begin
    state_d          = state_q;
    dmem_req         = 1'b0;
    sq_dequeued      = 1'b0;
    store_done_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_ready) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        dmem_req = 1'b1;
        if (dmem_resp) begin
          sq_dequeued      = 1'b1;
          store_done_valid = 1'b1;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register entries, pointers, occupancy count and FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SQ_LENGTH; i++) begin
        entries_q[i] <= '0;
        data_q[i]    <= 32'h0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
    end else begin
      entries_q <= entries_d;
      data_q    <= data_d;
      state_q   <= state_d;
      if (enq) begin
        tail_q <= tail_q + 1'b1;
      end
      if (sq_dequeued) begin
        head_q <= head_q + 1'b1;
      end
      case ({enq, sq_dequeued})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: reset, ready/late-operand stores, lane
// alignment, ROB-head gating, same-cycle CDB capture, full/wrap behaviour
// and reset while a request is outstanding.
module tb_store_queue;
  import rv32i_types::*;

  logic             clk;
  logic             rst;
  cdb_entry_t       cdb;
  cdb_entry_t       cdb2;
  dispatch_to_lsq_t dispatch_to_lsq;
  logic             dispatch_is_store;
  logic             dispatch_stall;
  logic             is_sq_full;
  logic [5:0]       ps1_s;
  logic [31:0]      ps1_value;
  logic [5:0]       ps2_s;
  logic [31:0]      ps2_value;
  logic [4:0]       rob_head_idx;
  dispatch_to_lsq_t squeue [4];
  logic [1:0]       sq_head;
  logic             sq_dequeued;
  logic             dmem_req;
  logic [31:0]      dmem_addr;
  logic [3:0]       dmem_wmask;
  logic [31:0]      dmem_wdata;
  logic             dmem_resp;
  logic             store_done_valid;
  logic [4:0]       store_done_rob_idx;

  int checks;
  int failures;

  store_queue dut (
    .clk                (clk),
    .rst                (rst),
    .cdb                (cdb),
    .cdb2               (cdb2),
    .dispatch_to_lsq    (dispatch_to_lsq),
    .dispatch_is_store  (dispatch_is_store),
    .dispatch_stall     (dispatch_stall),
    .is_sq_full         (is_sq_full),
    .ps1_s              (ps1_s),
    .ps1_value          (ps1_value),
    .ps2_s              (ps2_s),
    .ps2_value          (ps2_value),
    .rob_head_idx       (rob_head_idx),
    .squeue             (squeue),
    .sq_head            (sq_head),
    .sq_dequeued        (sq_dequeued),
    .dmem_req           (dmem_req),
    .dmem_addr          (dmem_addr),
    .dmem_wmask         (dmem_wmask),
    .dmem_wdata         (dmem_wdata),
    .dmem_resp          (dmem_resp),
    .store_done_valid   (store_done_valid),
    .store_done_rob_idx (store_done_rob_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cdb_entry_t mkCdb(input logic [5:0] pd, input logic [31:0] value);
    cdb_entry_t e;
    e.valid = 1'b1;
    e.pd    = pd;
    e.value = value;
    return e;
  endfunction

  task automatic applyStimulus(input logic [5:0] ps1, input logic p1v, input logic [5:0] ps2,
                               input logic p2v, input logic [31:0] imm, input logic [2:0] f3,
                               input logic [4:0] rob);
    dispatch_to_lsq.valid     = 1'b1;
    dispatch_to_lsq.ps1       = ps1;
    dispatch_to_lsq.ps1_valid = p1v;
    dispatch_to_lsq.ps2       = ps2;
    dispatch_to_lsq.ps2_valid = p2v;
    dispatch_to_lsq.imm       = imm;
    dispatch_to_lsq.funct3    = f3;
    dispatch_to_lsq.rob_idx   = rob;
    dispatch_is_store         = 1'b1;
  endtask

  task automatic clearDispatch();
    dispatch_to_lsq   = '0;
    dispatch_is_store = 1'b0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    cdb            = '0;
    cdb2           = '0;
    dispatch_stall = 1'b0;
    dmem_resp      = 1'b0;
    rob_head_idx   = 5'd0;
    ps1_value      = 32'h0;
    ps2_value      = 32'h0;
    clearDispatch();
    tick();
    tick();
    checkOutput("reset_req", dmem_req, 0);
    checkOutput("reset_full", is_sq_full, 0);
    checkOutput("reset_head", sq_head, 0);
    checkOutput("reset_deq", sq_dequeued, 0);
    checkOutput("reset_done", store_done_valid, 0);
    rst = 1'b0;

    // Ready SW: address 0x1000 + 8
    ps1_value = 32'h0000_1000;
    ps2_value = 32'hDEAD_BEEF;
    applyStimulus(6'd1, 1'b1, 6'd2, 1'b1, 32'h8, SW, 5'd0);
    #1;
    checkOutput("ps1_s", ps1_s, 1);
    checkOutput("ps2_s", ps2_s, 2);
    tick();
    clearDispatch();
    checkOutput("sw_imm", squeue[0].imm, 32'h1008);
    checkOutput("sw_req_not_yet", dmem_req, 0);
    tick();
    checkOutput("sw_req", dmem_req, 1);
    checkOutput("sw_addr", dmem_addr, 32'h1008);
    checkOutput("sw_wmask", dmem_wmask, 4'b1111);
    checkOutput("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    tick();
    tick();
    checkOutput("sw_req_held", dmem_req, 1);
    checkOutput("sw_no_early_deq", sq_dequeued, 0);
    dmem_resp = 1'b1;
    #1;
    checkOutput("sw_deq", sq_dequeued, 1);
    checkOutput("sw_done", store_done_valid, 1);
    checkOutput("sw_done_idx", store_done_rob_idx, 0);
    tick();
    dmem_resp = 1'b0;
    #1;
    checkOutput("sw_deq_single", sq_dequeued, 0);
    checkOutput("sw_head", sq_head, 1);
    checkOutput("sw_slot_freed", squeue[0].valid, 0);
    checkOutput("sw_req_drop", dmem_req, 0);

    // SB with base and data arriving later on the CDB
    rob_head_idx = 5'd1;
    ps1_value    = 32'h5555_5555;
    ps2_value    = 32'h6666_6666;
    applyStimulus(6'd5, 1'b0, 6'd6, 1'b0, 32'h3, SB, 5'd1);
    tick();
    clearDispatch();
    checkOutput("sb_imm_raw", squeue[1].imm, 32'h3);
    checkOutput("sb_ps1_wait", squeue[1].ps1_valid, 0);
    cdb = mkCdb(6'd5, 32'h2000);
    tick();
    checkOutput("sb_imm_woken", squeue[1].imm, 32'h2003);
    checkOutput("sb_ps1_woken", squeue[1].ps1_valid, 1);
    tick();
    checkOutput("sb_imm_dup", squeue[1].imm, 32'h2003);
    cdb = mkCdb(6'd6, 32'h0000_00AB);
    tick();
    cdb = '0;
    checkOutput("sb_ps2_woken", squeue[1].ps2_valid, 1);
    checkOutput("sb_req_not_yet", dmem_req, 0);
    tick();
    checkOutput("sb_req", dmem_req, 1);
    checkOutput("sb_addr", dmem_addr, 32'h2000);
    checkOutput("sb_wmask", dmem_wmask, 4'b1000);
    checkOutput("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    dmem_resp = 1'b1;
    #1;
    checkOutput("sb_done_idx", store_done_rob_idx, 1);
    tick();
    dmem_resp = 1'b0;
    #1;
    checkOutput("sb_head", sq_head, 2);

    // SH held back until it becomes the ROB head
    rob_head_idx = 5'd3;
    ps1_value    = 32'h3000;
    ps2_value    = 32'h0000_1234;
    applyStimulus(6'd7, 1'b1, 6'd8, 1'b1, 32'h2, SH, 5'd7);
    tick();
    clearDispatch();
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("rob_gate_no_req", dmem_req, 0);
    end
    rob_head_idx = 5'd7;
    tick();
    checkOutput("sh_req", dmem_req, 1);
    checkOutput("sh_addr", dmem_addr, 32'h3000);
    checkOutput("sh_wmask", dmem_wmask, 4'b1100);
    checkOutput("sh_wdata", dmem_wdata, 32'h1234_1234);
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    #1;
    checkOutput("sh_head", sq_head, 3);

    // Operands captured from both CDBs in the enqueue cycle
    rob_head_idx = 5'd9;
    ps1_value    = 32'h1111_1111;
    ps2_value    = 32'h2222_2222;
    cdb          = mkCdb(6'd10, 32'h4000);
    cdb2         = mkCdb(6'd11, 32'hCAFE_F00D);
    applyStimulus(6'd10, 1'b0, 6'd11, 1'b0, 32'h4, SW, 5'd8);
    tick();
    clearDispatch();
    cdb  = '0;
    cdb2 = '0;
    checkOutput("cdb_enq_ps1v", squeue[3].ps1_valid, 1);
    checkOutput("cdb_enq_ps2v", squeue[3].ps2_valid, 1);
    checkOutput("cdb_enq_imm", squeue[3].imm, 32'h4004);
    rob_head_idx = 5'd8;
    tick();
    checkOutput("cdb_req", dmem_req, 1);
    checkOutput("cdb_addr", dmem_addr, 32'h4004);
    checkOutput("cdb_wdata", dmem_wdata, 32'hCAFE_F00D);
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    #1;
    checkOutput("cdb_head_wrap", sq_head, 0);

    // Fill, refuse while full, retire-and-dispatch, tail wrap
    rob_head_idx = 5'd31;
    ps1_value    = 32'h100;
    ps2_value    = 32'h55;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(6'd1, 1'b1, 6'd2, 1'b1, 32'h0, SW, 5'(20 + k));
      tick();
    end
    checkOutput("fill_full", is_sq_full, 1);
    applyStimulus(6'd1, 1'b1, 6'd2, 1'b1, 32'h0, SW, 5'd24);
    tick();
    checkOutput("full_refused", squeue[0].rob_idx, 20);
    checkOutput("full_still", is_sq_full, 1);
    rob_head_idx = 5'd20;
    tick();
    checkOutput("full_retire_req", dmem_req, 1);
    applyStimulus(6'd1, 1'b1, 6'd2, 1'b1, 32'h0, SW, 5'd25);
    dmem_resp = 1'b1;
    #1;
    checkOutput("simul_full", is_sq_full, 1);
    checkOutput("simul_deq", sq_dequeued, 1);
    tick();
    dmem_resp = 1'b0;
    checkOutput("after_retire_full", is_sq_full, 0);
    checkOutput("after_retire_slot0", squeue[0].valid, 0);
    checkOutput("after_retire_head", sq_head, 1);
    tick();
    clearDispatch();
    checkOutput("wrap_slot0_valid", squeue[0].valid, 1);
    checkOutput("wrap_slot0_rob", squeue[0].rob_idx, 25);
    checkOutput("wrap_full", is_sq_full, 1);

    // Reset while a request is outstanding
    rob_head_idx = 5'd21;
    tick();
    checkOutput("pre_reset_req", dmem_req, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_req", dmem_req, 0);
    checkOutput("mid_reset_full", is_sq_full, 0);
    checkOutput("mid_reset_head", sq_head, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("mid_reset_valid", squeue[i].valid, 0);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    checkOutput("empty_no_req", dmem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
